clock_step_controller: RTL and testbench

//  Run/halt/single-step controller for the CPU clock-enable path. Replaces the

---
 rtl/clk_ctrl_pkg.sv | 12 +
 rtl/step_debouncer.sv | 45 ++++
 rtl/clock_step_controller.sv | 140 ++++++++++++++
 tb/tb_clock_step_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the run/halt/single-step clock controller.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } ctrl_state_t;

  localparam int DIV_DEFAULT = 5;

endpackage

// File: rtl/step_debouncer.sv
// Step button conditioner: 2-flop synchronizer, stability counter and rising-edge detect.
// Only instantiated when STEP_DEBOUNCE_EN is defined.
module step_debouncer #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_rise
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [1:0]    r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  assign w_accept = (r_sync[1] != r_stable) && (r_cnt == CW'(STABLE_CYCLES - 1));
  assign o_rise   = w_accept && r_sync[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_raw};
    end
  end

  // Any cycle agreeing with the accepted level restarts the stability window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (r_sync[1] == r_stable) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_stable <= r_sync[1];
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/clock_step_controller.sv
// Run/halt/single-step controller producing the CPU clock-enable strobe.
// Define STEP_DEBOUNCE_EN to synchronize and debounce the raw step button.
module clock_step_controller
  import clk_ctrl_pkg::*;
#(
  parameter int DIV_W           = 28,
  parameter int DIV_DEFAULT     = clk_ctrl_pkg::DIV_DEFAULT,
  parameter int CYC_W           = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             in_clock,
  input  logic             reset_n,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic             tick_en,
  output logic             running,
  output logic             halted,
  output logic [CYC_W-1:0] tick_count,
  output logic [DIV_W-1:0] div_active
);

  ctrl_state_t      r_state;
  ctrl_state_t      w_next;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [CYC_W-1:0] r_tick_count;
  logic             r_tick_en;
  logic             r_running;
  logic             r_halted;
  logic             w_step_edge;
  logic             w_terminal;
  logic             w_tick_next;
  logic             w_running_next;
  logic             w_halted_next;

`ifdef STEP_DEBOUNCE_EN
  step_debouncer #(
    .STABLE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debouncer (
    .i_clk  (in_clock),
    .i_rst_n(reset_n),
    .i_raw  (step_req),
    .o_rise (w_step_edge)
  );
`else
  logic r_step_q;
  logic w_unused;

  assign w_unused    = (DEBOUNCE_CYCLES != 0);
  assign w_step_edge = step_req & ~r_step_q;

  always_ff @(posedge in_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_step_q <= 1'b0;
    end else begin
      r_step_q <= step_req;
    end
  end
`endif

  assign w_terminal = (r_cnt == r_div - DIV_W'(1));

  always_ff @(posedge in_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= HALT;
      r_tick_en <= 1'b0;
      r_running <= 1'b0;
      r_halted  <= 1'b1;
    end else begin
      r_state   <= w_next;
      r_tick_en <= w_tick_next;
      r_running <= w_running_next;
      r_halted  <= w_halted_next;
    end
  end

  // A step edge in HALT outranks run_req; halt/run-drop outranks a terminal count.
  always_comb begin
    w_next = r_state;
    case (r_state)
      HALT: begin
        if (w_step_edge) begin
          w_next = STEP;
        end else if (run_req && !halt_req) begin
          w_next = RUN;
        end
      end
      RUN: begin
        if (!run_req || halt_req) begin
          w_next = HALT;
        end
      end
      STEP:    w_next = HALT;
      default: w_next = HALT;
    endcase
  end

  always_comb begin
    w_tick_next    = (w_next == STEP) || ((r_state == RUN) && (w_next == RUN) && w_terminal);
    w_running_next = (w_next == RUN);
    w_halted_next  = (w_next == HALT);
  end

  always_ff @(posedge in_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if ((r_state == RUN) && (w_next == RUN)) begin
      r_cnt <= w_terminal ? '0 : r_cnt + DIV_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // Divisors of 0 and 1 both mean a strobe every cycle.
  always_ff @(posedge in_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= DIV_W'(DIV_DEFAULT);
    end else if ((r_state == HALT) && div_load) begin
      r_div <= (div_value <= DIV_W'(1)) ? DIV_W'(1) : div_value;
    end
  end

  always_ff @(posedge in_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_count <= '0;
    end else if (w_tick_next) begin
      r_tick_count <= r_tick_count + CYC_W'(1);
    end
  end

  assign tick_en    = r_tick_en;
  assign running    = r_running;
  assign halted     = r_halted;
  assign tick_count = r_tick_count;
  assign div_active = r_div;

endmodule

// File: tb/tb_clock_step_controller.sv
// Directed self-checking bench for clock_step_controller (tick_count narrowed to 4 bits).
module tb_clock_step_controller;

  localparam int DIV_W = 28;
  localparam int CYC_W = 4;

  logic             clk = 1'b0;
  logic             rstN;
  logic             runReq;
  logic             stepReq;
  logic             haltReq;
  logic             divLoad;
  logic [DIV_W-1:0] divValue;
  logic             tickEn;
  logic             runningOut;
  logic             haltedOut;
  logic [CYC_W-1:0] tickCount;
  logic [DIV_W-1:0] divActive;

  int               compared   = 0;
  int               mismatched = 0;
  logic [CYC_W-1:0] expCount   = '0;
  int               nTicks;

  clock_step_controller #(
    .DIV_W          (DIV_W),
    .DIV_DEFAULT    (5),
    .CYC_W          (CYC_W),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .in_clock  (clk),
    .reset_n   (rstN),
    .run_req   (runReq),
    .step_req  (stepReq),
    .halt_req  (haltReq),
    .div_load  (divLoad),
    .div_value (divValue),
    .tick_en   (tickEn),
    .running   (runningOut),
    .halted    (haltedOut),
    .tick_count(tickCount),
    .div_active(divActive)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic run, input logic halt, input logic step,
                               input logic load, input logic [DIV_W-1:0] value);
    runReq   = run;
    haltReq  = halt;
    stepReq  = step;
    divLoad  = load;
    divValue = value;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(0, 0, 0, 0, '0);
    #12;
    rstN = 1'b1;
    #1;
    checkOutput("reset tick_en", tickEn, 0);
    checkOutput("reset running", runningOut, 0);
    checkOutput("reset halted", haltedOut, 1);
    checkOutput("reset tick_count", tickCount, 0);
    checkOutput("reset div_active", divActive, 5);

    // Free-run with the default divisor of 5
    applyStimulus(1, 0, 0, 0, '0);
    stepCycle();
    checkOutput("t1 running", runningOut, 1);
    checkOutput("t1 halted", haltedOut, 0);
    checkOutput("t1 entry tick", tickEn, 0);
    for (int k = 1; k <= 15; k++) begin
      stepCycle();
      checkOutput("t1 tick_en", tickEn, (k % 5 == 0) ? 1 : 0);
      if (k % 5 == 0) begin
        expCount++;
        checkOutput("t1 tick_count", tickCount, expCount);
      end
    end

    // Divisor load: ignored on the RUN->HALT edge, honoured in HALT, ignored in RUN
    applyStimulus(0, 0, 0, 1, 28'd3);
    stepCycle();
    checkOutput("t2 halted", haltedOut, 1);
    checkOutput("t2 load ignored in RUN", divActive, 5);
    stepCycle();
    checkOutput("t2 div_active", divActive, 3);
    applyStimulus(1, 0, 0, 0, '0);
    stepCycle();
    checkOutput("t2 running", runningOut, 1);
    applyStimulus(1, 0, 0, 1, 28'd7);
    for (int k = 1; k <= 9; k++) begin
      stepCycle();
      checkOutput("t2 tick_en", tickEn, (k % 3 == 0) ? 1 : 0);
      if (k % 3 == 0) begin
        expCount++;
        checkOutput("t2 tick_count", tickCount, expCount);
      end
    end
    checkOutput("t2 div kept in RUN", divActive, 3);

    // Held step button gives exactly one strobe
    applyStimulus(0, 0, 0, 0, '0);
    stepCycle();
    checkOutput("t3 halted", haltedOut, 1);
    applyStimulus(0, 0, 1, 0, '0);
    nTicks = 0;
    for (int k = 0; k < 40; k++) begin
      stepCycle();
      if (tickEn) nTicks++;
    end
    checkOutput("t3 one tick", nTicks, 1);
    expCount++;
    checkOutput("t3 tick_count", tickCount, expCount);
    checkOutput("t3 back in HALT", haltedOut, 1);
    applyStimulus(0, 0, 0, 0, '0);
    nTicks = 0;
    for (int k = 0; k < 40; k++) begin
      stepCycle();
      if (tickEn) nTicks++;
    end
    checkOutput("t3 release no tick", nTicks, 0);

`ifndef STEP_DEBOUNCE_EN
    // Step edge and run_req together in HALT: step first, RUN one HALT cycle later
    applyStimulus(1, 0, 1, 0, '0);
    stepCycle();
    expCount++;
    checkOutput("sw tick_en", tickEn, 1);
    checkOutput("sw running", runningOut, 0);
    checkOutput("sw halted", haltedOut, 0);
    stepCycle();
    checkOutput("sw halt tick_en", tickEn, 0);
    checkOutput("sw halted again", haltedOut, 1);
    stepCycle();
    checkOutput("sw run entered", runningOut, 1);
    applyStimulus(0, 0, 0, 0, '0);
    stepCycle();
    checkOutput("sw tick_count", tickCount, expCount);
`endif

    // halt_req on the terminal-count cycle suppresses the strobe
    applyStimulus(1, 0, 0, 0, '0);
    stepCycle();
    checkOutput("t4 running", runningOut, 1);
    stepCycle();
    stepCycle();
    checkOutput("t4 pre-terminal tick", tickEn, 0);
    applyStimulus(1, 1, 0, 0, '0);
    stepCycle();
    checkOutput("t4 no strobe", tickEn, 0);
    checkOutput("t4 halted", haltedOut, 1);
    checkOutput("t4 tick_count", tickCount, expCount);
    for (int k = 0; k < 5; k++) begin
      stepCycle();
      checkOutput("t4 held halt", haltedOut, 1);
    end
    applyStimulus(1, 0, 0, 0, '0);
    stepCycle();
    checkOutput("t4 resume", runningOut, 1);
    for (int k = 1; k <= 3; k++) begin
      stepCycle();
      checkOutput("t4 resume tick", tickEn, (k == 3) ? 1 : 0);
    end
    expCount++;
    checkOutput("t4 resume count", tickCount, expCount);

    // Divisor 0 behaves as 1; tick_count wraps at 4 bits
    applyStimulus(0, 0, 0, 0, '0);
    stepCycle();
    applyStimulus(0, 0, 0, 1, 28'd0);
    stepCycle();
    checkOutput("t5 div_active", divActive, 1);
    applyStimulus(1, 0, 0, 0, '0);
    stepCycle();
    checkOutput("t5 entry tick", tickEn, 0);
    for (int k = 1; k <= 17; k++) begin
      stepCycle();
      expCount++;
      checkOutput("t5 tick_en", tickEn, 1);
      checkOutput("t5 tick_count", tickCount, expCount);
    end

    // Asynchronous reset between clock edges while running
    #3;
    rstN = 1'b0;
    #1;
    expCount = '0;
    checkOutput("t6 tick_en", tickEn, 0);
    checkOutput("t6 running", runningOut, 0);
    checkOutput("t6 halted", haltedOut, 1);
    checkOutput("t6 tick_count", tickCount, 0);
    checkOutput("t6 div_active", divActive, 5);
    applyStimulus(0, 0, 0, 0, '0);
    #2;
    rstN = 1'b1;
    stepCycle();
    checkOutput("t6 stays halted", haltedOut, 1);

`ifdef STEP_DEBOUNCE_EN
    // Short glitches on the step button never reach the debounced edge
    nTicks = 0;
    for (int g = 0; g < 3; g++) begin
      applyStimulus(0, 0, 1, 0, '0);
      for (int k = 0; k < 3; k++) begin
        stepCycle();
        if (tickEn) nTicks++;
      end
      applyStimulus(0, 0, 0, 0, '0);
      for (int k = 0; k < 5; k++) begin
        stepCycle();
        if (tickEn) nTicks++;
      end
    end
    for (int k = 0; k < 30; k++) begin
      stepCycle();
      if (tickEn) nTicks++;
    end
    checkOutput("t6 glitch no tick", nTicks, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
